// File: rtl/wb_line_prefetch.sv
// rtl/wb_line_prefetch.sv - single-line read prefetch buffer between a CPU Wishbone master and a DDR port
// Optional hit/miss counters are enabled by defining WB_LINE_PREFETCH_STATS_EN.
module wb_line_prefetch #(
  parameter int ADDR_WIDTH      = 26,
  parameter int LINE_WORDS_LOG2 = 2
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        inv_i
`ifdef WB_LINE_PREFETCH_STATS_EN
  ,
  output logic [15:0] hit_cnt_o,
  output logic [15:0] miss_cnt_o
`endif
);

  localparam int LINE_WORDS = 1 << LINE_WORDS_LOG2;
  localparam int OFF_BITS   = LINE_WORDS_LOG2 + 2;
  localparam int TAG_W      = ADDR_WIDTH - OFF_BITS;

  typedef logic [LINE_WORDS_LOG2-1:0] beat_t;
  localparam beat_t LAST_BEAT = beat_t'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_ACK} state_t;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  beat_t            beat_q, beat_d;
  logic [31:0]      line_q [LINE_WORDS];
  logic [31:0]      line_d [LINE_WORDS];
  logic [31:0]      sdat_q, sdat_d;
  logic             sack_q, sack_d;
  logic [31:0]      madr_q, madr_d;
  logic [31:0]      mdat_q, mdat_d;
  logic [3:0]       msel_q, msel_d;
  logic             mwe_q, mwe_d;
  logic             mcyc_q, mcyc_d;
  logic             mstb_q, mstb_d;
  logic [2:0]       mcti_q, mcti_d;
  logic [1:0]       mbte_q, mbte_d;
`ifdef WB_LINE_PREFETCH_STATS_EN
  logic [15:0]      hit_cnt_q, hit_cnt_d;
  logic [15:0]      miss_cnt_q, miss_cnt_d;
`endif

  logic  hit;
  beat_t wr_word;
  logic  unused;

  // Slave burst hints are deliberately dropped: every slave beat is a classic cycle.
  assign unused  = ^{wbs_cti_i, wbs_bte_i};
  // An invalidate arriving with the lookup wins, so the read refetches.
  assign hit     = valid_q && !inv_i && (tag_q == wbs_adr_i[ADDR_WIDTH-1:OFF_BITS]);
  assign wr_word = madr_q[OFF_BITS-1:2];

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    beat_d  = beat_q;
    line_d  = line_q;
    sdat_d  = sdat_q;
    sack_d  = 1'b0;
    madr_d  = madr_q;
    mdat_d  = mdat_q;
    msel_d  = msel_q;
    mwe_d   = mwe_q;
    mcyc_d  = mcyc_q;
    mstb_d  = mstb_q;
    mcti_d  = mcti_q;
    mbte_d  = mbte_q;
`ifdef WB_LINE_PREFETCH_STATS_EN
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (wbs_we_i) begin
            state_d = S_WRITE;
            madr_d  = wbs_adr_i;
            mdat_d  = wbs_dat_i;
            msel_d  = wbs_sel_i;
            mwe_d   = 1'b1;
            mcyc_d  = 1'b1;
            mstb_d  = 1'b1;
            mcti_d  = 3'b000;
            mbte_d  = 2'b00;
          end else if (hit) begin
            state_d = S_ACK;
            sack_d  = 1'b1;
            sdat_d  = line_q[wbs_adr_i[OFF_BITS-1:2]];
`ifdef WB_LINE_PREFETCH_STATS_EN
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
`endif
          end else begin
            state_d = S_FILL;
            beat_d  = '0;
            madr_d  = {wbs_adr_i[31:OFF_BITS], {OFF_BITS{1'b0}}};
            msel_d  = 4'hF;
            mwe_d   = 1'b0;
            mcyc_d  = 1'b1;
            mstb_d  = 1'b1;
            mcti_d  = 3'b010;
            mbte_d  = 2'b00;
`ifdef WB_LINE_PREFETCH_STATS_EN
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
`endif
          end
        end
      end
      S_FILL: begin
        if (wbm_ack_i) begin
          line_d[beat_q] = wbm_dat_i;
          beat_d         = beat_q + beat_t'(1);
          madr_d         = madr_q + 32'd4;
          if (beat_q == LAST_BEAT - beat_t'(1)) mcti_d = 3'b111;
          if (beat_q == LAST_BEAT) begin
            // The held slave read is then served from the buffer as an ordinary hit.
            state_d = S_IDLE;
            tag_d   = madr_q[ADDR_WIDTH-1:OFF_BITS];
            valid_d = 1'b1;
            madr_d  = madr_q;
            mcyc_d  = 1'b0;
            mstb_d  = 1'b0;
            mcti_d  = 3'b000;
          end
        end
      end
      S_WRITE: begin
        if (wbm_ack_i) begin
          state_d = S_ACK;
          sack_d  = 1'b1;
          mcyc_d  = 1'b0;
          mstb_d  = 1'b0;
          mwe_d   = 1'b0;
          if (valid_q && tag_q == madr_q[ADDR_WIDTH-1:OFF_BITS]) begin
            for (int b = 0; b < 4; b++) begin
              if (msel_q[b]) line_d[wr_word][8*b +: 8] = mdat_q[8*b +: 8];
            end
          end
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (inv_i) valid_d = 1'b0;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      beat_q  <= '0;
      for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= '0;
      sdat_q  <= '0;
      sack_q  <= 1'b0;
      madr_q  <= '0;
      mdat_q  <= '0;
      msel_q  <= '0;
      mwe_q   <= 1'b0;
      mcyc_q  <= 1'b0;
      mstb_q  <= 1'b0;
      mcti_q  <= '0;
      mbte_q  <= '0;
`ifdef WB_LINE_PREFETCH_STATS_EN
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      sdat_q  <= sdat_d;
      sack_q  <= sack_d;
      madr_q  <= madr_d;
      mdat_q  <= mdat_d;
      msel_q  <= msel_d;
      mwe_q   <= mwe_d;
      mcyc_q  <= mcyc_d;
      mstb_q  <= mstb_d;
      mcti_q  <= mcti_d;
      mbte_q  <= mbte_d;
`ifdef WB_LINE_PREFETCH_STATS_EN
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
`endif
    end
  end

  assign wbs_dat_o = sdat_q;
  assign wbs_ack_o = sack_q;
  assign wbm_adr_o = madr_q;
  assign wbm_dat_o = mdat_q;
  assign wbm_sel_o = msel_q;
  assign wbm_we_o  = mwe_q;
  assign wbm_cyc_o = mcyc_q;
  assign wbm_stb_o = mstb_q;
  assign wbm_cti_o = mcti_q;
  assign wbm_bte_o = mbte_q;
`ifdef WB_LINE_PREFETCH_STATS_EN
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
